// File: rtl/vproc_vreg_wr_arb_if.sv
// Request bus between the execution-unit result stages and the vreg write-port arbiter.
// Flattened per-requester fields, with index order following op_unit.
interface vproc_vreg_wr_arb_if #(
  parameter int PORT_CNT = 7,
  parameter int VREG_W   = 128
);
  logic [PORT_CNT-1:0]            req_valid;
  logic [PORT_CNT-1:0]            req_ready;
  logic [PORT_CNT*5-1:0]          req_addr;
  logic [PORT_CNT*VREG_W/8-1:0]   req_be;
  logic [PORT_CNT*VREG_W-1:0]     req_data;
  logic [PORT_CNT-1:0]            req_last;

  modport master (
    output req_valid, req_addr, req_be, req_data, req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_addr, req_be, req_data, req_last,
    output req_ready
  );
endinterface

// File: rtl/vproc_vreg_wr_arb.sv
// Round-robin arbiter sharing the single vreg file write port among the execution units.
// Optional VPROC_WR_ARB_LOCK_EN keeps a multi-register write group on the port until its last beat.
module vproc_vreg_wr_arb #(
  parameter int PORT_CNT = 7,
  parameter int VREG_W   = 128
) (
  input  logic                  clk_i,
  input  logic                  sync_rst_i,
  vproc_vreg_wr_arb_if.slave    req_if,
  output logic                  vreg_wr_en_o,
  output logic [4:0]            vreg_wr_addr_o,
  output logic [VREG_W/8-1:0]   vreg_wr_be_o,
  output logic [VREG_W-1:0]     vreg_wr_o,
  output logic [31:0]           vreg_wr_clr_o
);

  localparam int RR_W = (PORT_CNT > 1) ? $clog2(PORT_CNT) : 1;

  logic [RR_W-1:0]       rr_q, rr_d, rr_nxt;
  logic [PORT_CNT-1:0]   elig, gnt_oh;
  logic                  gnt_vld;
  logic [RR_W-1:0]       gnt_idx;
  logic [4:0]            sel_addr;
  logic [VREG_W/8-1:0]   sel_be;
  logic [VREG_W-1:0]     sel_data;
  logic                  sel_last;

  logic                  en_q;
  logic [4:0]            addr_q;
  logic [VREG_W/8-1:0]   be_q;
  logic [VREG_W-1:0]     data_q;

`ifdef VPROC_WR_ARB_LOCK_EN
  logic                  lock_q, lock_d;
  logic [RR_W-1:0]       lock_idx_q, lock_idx_d;
`else
  logic                  unused_last;
  assign unused_last = ^req_if.req_last;
`endif

  // Grant: first eligible index at or after rr_q, wrapping to the lowest index otherwise.
  always_comb begin
    elig = req_if.req_valid & {PORT_CNT{~sync_rst_i}};
`ifdef VPROC_WR_ARB_LOCK_EN
    if (lock_q) begin
      for (int i = 0; i < PORT_CNT; i++) begin
        if (i != int'(lock_idx_q)) elig[i] = 1'b0;
      end
    end
`endif
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < PORT_CNT; i++) begin
      if (!gnt_vld && elig[i] && (i >= int'(rr_q))) begin
        gnt_vld = 1'b1;
        gnt_idx = RR_W'(i);
      end
    end
    for (int i = 0; i < PORT_CNT; i++) begin
      if (!gnt_vld && elig[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = RR_W'(i);
      end
    end
  end

  always_comb begin
    gnt_oh   = '0;
    sel_addr = '0;
    sel_be   = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < PORT_CNT; i++) begin
      gnt_oh[i] = gnt_vld && (gnt_idx == RR_W'(i));
      if (gnt_oh[i]) begin
        sel_addr = req_if.req_addr[i*5 +: 5];
        sel_be   = req_if.req_be[i*(VREG_W/8) +: (VREG_W/8)];
        sel_data = req_if.req_data[i*VREG_W +: VREG_W];
        sel_last = req_if.req_last[i];
      end
    end
  end

  assign req_if.req_ready = gnt_oh;
  assign rr_nxt = (int'(gnt_idx) == PORT_CNT - 1) ? '0 : RR_W'(gnt_idx + 1'b1);

  always_comb begin
    rr_d = rr_q;
`ifdef VPROC_WR_ARB_LOCK_EN
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (gnt_vld) begin
      if (sel_last) begin
        lock_d = 1'b0;
        rr_d   = rr_nxt;
      end else begin
        lock_d     = 1'b1;
        lock_idx_d = gnt_idx;
      end
    end
`else
    if (gnt_vld) rr_d = rr_nxt;
`endif
  end

  // Write-port register stage: payload holds when idle, en qualifies it.
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      rr_q   <= '0;
      en_q   <= 1'b0;
      addr_q <= '0;
      be_q   <= '0;
      data_q <= '0;
`ifdef VPROC_WR_ARB_LOCK_EN
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
`endif
    end else begin
      rr_q <= rr_d;
      en_q <= gnt_vld;
      if (gnt_vld) begin
        addr_q <= sel_addr;
        be_q   <= sel_be;
        data_q <= sel_data;
      end
`ifdef VPROC_WR_ARB_LOCK_EN
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
`endif
    end
  end

  assign vreg_wr_en_o   = en_q;
  assign vreg_wr_addr_o = addr_q;
  assign vreg_wr_be_o   = be_q;
  assign vreg_wr_o      = data_q;
  assign vreg_wr_clr_o  = en_q ? (32'd1 << addr_q) : 32'd0;

endmodule

// File: tb/tb_vproc_vreg_wr_arb.sv
// Directed testbench for vproc_vreg_wr_arb; expected grant orders and payloads are hand-derived.
module tb_vproc_vreg_wr_arb;
  localparam int P  = 7;
  localparam int W  = 128;
  localparam int BE = W / 8;

  logic           clk;
  logic           rst;
  logic           wr_en;
  logic [4:0]     wr_addr;
  logic [BE-1:0]  wr_be;
  logic [W-1:0]   wr_data;
  logic [31:0]    wr_clr;
  int             n_pass;
  int             n_total;

  vproc_vreg_wr_arb_if #(.PORT_CNT(P), .VREG_W(W)) ifc ();

  vproc_vreg_wr_arb #(.PORT_CNT(P), .VREG_W(W)) dut (
    .clk_i          (clk),
    .sync_rst_i     (rst),
    .req_if         (ifc.slave),
    .vreg_wr_en_o   (wr_en),
    .vreg_wr_addr_o (wr_addr),
    .vreg_wr_be_o   (wr_be),
    .vreg_wr_o      (wr_data),
    .vreg_wr_clr_o  (wr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int u, input logic [4:0] a, input logic [W-1:0] d,
                         input logic [BE-1:0] b, input logic l);
    ifc.req_addr[u*5 +: 5]    = a;
    ifc.req_data[u*W +: W]    = d;
    ifc.req_be[u*BE +: BE]    = b;
    ifc.req_last[u]           = l;
    ifc.req_valid[u]          = 1'b1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    ifc.req_valid = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int u = 0; u < P; u++) set_req(u, 5'(u), W'(u), '1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step();
      n_total++;
      if (ifc.req_ready !== 7'b0) $display("FAIL rst_ready cyc%0d got %b exp 0", c, ifc.req_ready);
      else n_pass++;
      n_total++;
      if (wr_en !== 1'b0) $display("FAIL rst_en cyc%0d got %b exp 0", c, wr_en);
      else n_pass++;
    end
    rst = 1'b0;
    ifc.req_valid = '0;
    n_total++;
    if (wr_en !== 1'b0 || wr_clr !== 32'd0)
      $display("FAIL rst_after en=%b clr=%h exp 0/0", wr_en, wr_clr);
    else n_pass++;
    step();
  endtask

  task automatic test_single();
    logic [W-1:0] d;
    d = {16{8'hA5}};
    set_req(2, 5'd9, d, 16'hFFFF, 1'b1);
    #1;
    n_total++;
    if (ifc.req_ready !== 7'b0000100) $display("FAIL single_ready got %b exp 0000100", ifc.req_ready);
    else n_pass++;
    step();
    ifc.req_valid = '0;
    #1;
    n_total++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd9 || wr_be !== 16'hFFFF || wr_data !== d)
      $display("FAIL single_port en=%b addr=%0d be=%h data=%h exp 1/9/ffff/%h", wr_en, wr_addr, wr_be, wr_data, d);
    else n_pass++;
    n_total++;
    if (wr_clr !== 32'h200) $display("FAIL single_clr got %h exp 00000200", wr_clr);
    else n_pass++;
    n_total++;
    if (ifc.req_ready !== 7'b0) $display("FAIL idle_ready got %b exp 0", ifc.req_ready);
    else n_pass++;
    step();
    n_total++;
    if (wr_en !== 1'b0 || wr_addr !== 5'd9 || wr_clr !== 32'd0)
      $display("FAIL idle_hold en=%b addr=%0d clr=%h exp 0/9/0", wr_en, wr_addr, wr_clr);
    else n_pass++;
  endtask

  task automatic test_pointer_skip();
    set_req(0, 5'd1, W'(32'h11), 16'h000F, 1'b1);
    set_req(1, 5'd2, W'(32'h22), 16'h00F0, 1'b1);
    #1;
    n_total++;
    if (ifc.req_ready !== 7'b0000001) $display("FAIL skip_ready got %b exp 0000001", ifc.req_ready);
    else n_pass++;
    step();
    set_req(0, 5'd1, W'(32'h11), 16'h000F, 1'b1);
    #1;
    n_total++;
    if (ifc.req_ready !== 7'b0000010) $display("FAIL skip_next_ready got %b exp 0000010", ifc.req_ready);
    else n_pass++;
    n_total++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd1 || wr_be !== 16'h000F)
      $display("FAIL skip_port en=%b addr=%0d be=%h exp 1/1/000f", wr_en, wr_addr, wr_be);
    else n_pass++;
    step();
    ifc.req_valid = '0;
    n_total++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd2 || wr_data !== W'(32'h22))
      $display("FAIL skip_port2 en=%b addr=%0d data=%h exp 1/2/22", wr_en, wr_addr, wr_data);
    else n_pass++;
    step();
  endtask

  task automatic test_all_valid();
    int e;
    logic [6:0]    er;
    logic [BE-1:0] eb;
    reset_dut();
    for (int u = 0; u < P; u++) set_req(u, 5'(10 + u), W'(32'hA000 + u), 16'h0101 << u, 1'b1);
    for (int c = 0; c < 14; c++) begin
      e  = c % P;
      er = 7'b1 << e;
      eb = 16'h0101 << e;
      #1;
      n_total++;
      if (ifc.req_ready !== er) $display("FAIL rr_ready cyc%0d got %b exp %b", c, ifc.req_ready, er);
      else n_pass++;
      step();
      n_total++;
      if (wr_en !== 1'b1 || wr_addr !== 5'(10 + e) || wr_be !== eb || wr_data !== W'(32'hA000 + e))
        $display("FAIL rr_port cyc%0d en=%b addr=%0d be=%h exp 1/%0d/%h", c, wr_en, wr_addr, wr_be, 10 + e, eb);
      else n_pass++;
      n_total++;
      if (wr_clr !== (32'd1 << (10 + e))) $display("FAIL rr_clr cyc%0d got %h exp %h", c, wr_clr, 32'd1 << (10 + e));
      else n_pass++;
    end
    ifc.req_valid = '0;
    step();
    n_total++;
    if (wr_en !== 1'b0) $display("FAIL rr_drain en got %b exp 0", wr_en);
    else n_pass++;
  endtask

  task automatic test_lock_interleave();
    int seq [6];
    int beat5;
    int e;
    logic [4:0]   ea;
    logic [W-1:0] ed;
`ifdef VPROC_WR_ARB_LOCK_EN
    seq = '{5, 5, 5, 5, 1, 2};
`else
    seq = '{5, 1, 2, 5, 5, 5};
`endif
    set_req(4, 5'd4, W'(32'h44), '1, 1'b1);
    step();
    ifc.req_valid = '0;
    beat5 = 0;
    set_req(5, 5'd20, W'(32'hD000_0000), '1, 1'b0);
    set_req(1, 5'd21, W'(32'hC000_0001), '1, 1'b1);
    set_req(2, 5'd22, W'(32'hC000_0002), '1, 1'b1);
    for (int c = 0; c < 6; c++) begin
      e  = seq[c];
      ea = (e == 5) ? 5'd20 : 5'(20 + e);
      ed = (e == 5) ? W'(32'hD000_0000 + beat5) : W'(32'hC000_0000 + e);
      #1;
      n_total++;
      if (ifc.req_ready !== (7'b1 << e)) $display("FAIL grp_ready cyc%0d got %b exp %b", c, ifc.req_ready, 7'b1 << e);
      else n_pass++;
      step();
      if (e == 5) begin
        beat5++;
        if (beat5 == 4) ifc.req_valid[5] = 1'b0;
        else set_req(5, 5'd20, W'(32'hD000_0000 + beat5), '1, (beat5 == 3));
      end else begin
        ifc.req_valid[e] = 1'b0;
      end
      n_total++;
      if (wr_en !== 1'b1 || wr_addr !== ea || wr_data !== ed)
        $display("FAIL grp_port cyc%0d en=%b addr=%0d data=%h exp 1/%0d/%h", c, wr_en, wr_addr, wr_data, ea, ed);
      else n_pass++;
    end
    #1;
    n_total++;
    if (ifc.req_ready !== 7'b0) $display("FAIL grp_done_ready got %b exp 0", ifc.req_ready);
    else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    set_req(4, 5'd7, W'(32'h77), '1, 1'b1);
    step();
    ifc.req_valid = '0;
    rst = 1'b1;
    set_req(3, 5'd13, W'(32'h33), '1, 1'b1);
    set_req(6, 5'd16, W'(32'h66), '1, 1'b1);
    #1;
    n_total++;
    if (ifc.req_ready !== 7'b0) $display("FAIL mid_rst_ready got %b exp 0", ifc.req_ready);
    else n_pass++;
    n_total++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd7) $display("FAIL mid_inflight en=%b addr=%0d exp 1/7", wr_en, wr_addr);
    else n_pass++;
    step();
    rst = 1'b0;
    n_total++;
    if (wr_en !== 1'b0 || wr_clr !== 32'd0) $display("FAIL mid_drop en=%b clr=%h exp 0/0", wr_en, wr_clr);
    else n_pass++;
    #1;
    n_total++;
    if (ifc.req_ready !== 7'b0001000) $display("FAIL mid_regrant got %b exp 0001000", ifc.req_ready);
    else n_pass++;
    step();
    ifc.req_valid[3] = 1'b0;
    n_total++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd13) $display("FAIL mid_port3 en=%b addr=%0d exp 1/13", wr_en, wr_addr);
    else n_pass++;
    #1;
    n_total++;
    if (ifc.req_ready !== 7'b1000000) $display("FAIL mid_next got %b exp 1000000", ifc.req_ready);
    else n_pass++;
    step();
    ifc.req_valid = '0;
    n_total++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd16) $display("FAIL mid_port6 en=%b addr=%0d exp 1/16", wr_en, wr_addr);
    else n_pass++;
    step();
    n_total++;
    if (wr_en !== 1'b0) $display("FAIL mid_idle en got %b exp 0", wr_en);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    ifc.req_valid = '0;
    ifc.req_addr  = '0;
    ifc.req_be    = '0;
    ifc.req_data  = '0;
    ifc.req_last  = '0;
    test_reset();
    test_single();
    test_pointer_skip();
    test_all_valid();
    test_lock_interleave();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
